// File: rtl/zcu216_clk_pkg.sv
// Shared types and default parameters for the ZCU216 ADC-clock reset sequencer.
package zcu216_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam int DEF_HOLD_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/zcu216_sync_bit.sv
// Single-bit flop-chain synchronizer with synchronous clear; the last stage is the
// synchronized output.
module zcu216_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/zcu216_clk_rst_sequencer.sv
// Holds ADC-clock logic in reset until MMCM lock has been stable for HOLD_CYCLES.
// Optional lock-loss counter is built only when ZCU216_CLK_SEQ_LOSS_CNT_EN is defined.
module zcu216_clk_rst_sequencer
  import zcu216_clk_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             adc_clk,
  input  logic             adc_rst,
  input  logic             mmcm_locked,
  input  logic             rst_req,
  output logic             user_rst,
  output logic             clk_ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]       seq_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             locked_s;
  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic             loss_event;

  zcu216_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(adc_clk),
    .clr(adc_rst),
    .d  (mmcm_locked),
    .q  (locked_s)
  );

  // Anything that does not explicitly stay or advance falls back to WAIT_LOCK,
  // which also recovers the unused encoding.
  always_comb begin
    state_next    = WAIT_LOCK;
    hold_cnt_next = '0;
    loss_event    = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s && !rst_req) state_next = HOLD;
      end
      HOLD: begin
        if (!locked_s || rst_req) begin
          state_next = WAIT_LOCK;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
        end else begin
          state_next    = HOLD;
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          loss_event = 1'b1;
        end else if (!rst_req) begin
          state_next = RUN;
        end
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      user_rst  <= 1'b1;
      clk_ready <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      user_rst  <= (state_next != RUN);
      clk_ready <= (state_next == RUN);
    end
  end

  assign seq_state = state;

`ifdef ZCU216_CLK_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      loss_cnt <= '0;
    end else if (loss_event && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
  assign lock_loss_cnt     = '0;
`endif

endmodule

// File: tb/tb_zcu216_clk_rst_sequencer.sv
// Directed plus randomized bench for zcu216_clk_rst_sequencer, checked against a
// lock-streak reference model.
module tb_zcu216_clk_rst_sequencer;

  localparam int HOLD_CYCLES = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
`ifdef ZCU216_CLK_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             adc_clk = 1'b0;
  logic             adc_rst;
  logic             mmcm_locked;
  logic             rst_req;
  logic             user_rst;
  logic             clk_ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [1:0]       seq_state;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the last SYNC_STAGES lock samples, and the number of
  // consecutive edges that saw synchronized lock with no reset request.
  bit sync_q[$];
  int streak;
  int loss_model;

  always #5 adc_clk = ~adc_clk;

  zcu216_clk_rst_sequencer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .adc_clk      (adc_clk),
    .adc_rst      (adc_rst),
    .mmcm_locked  (mmcm_locked),
    .rst_req      (rst_req),
    .user_rst     (user_rst),
    .clk_ready    (clk_ready),
    .lock_loss_cnt(lock_loss_cnt),
    .seq_state    (seq_state)
  );

  task automatic checkOutput();
    logic [1:0]       exp_state;
    logic             exp_rst;
    logic [CNT_W-1:0] exp_cnt;
    if (streak == 0)                exp_state = 2'd0;
    else if (streak <= HOLD_CYCLES) exp_state = 2'd1;
    else                            exp_state = 2'd2;
    exp_rst = (exp_state != 2'd2);
    exp_cnt = CNT_W'(loss_model);

    vectors++;
    assert (seq_state === exp_state) else begin
      miscompares++;
      $error("[TB] FAIL seq_state t=%0t observed=%0d expected=%0d", $time, seq_state, exp_state);
    end
    vectors++;
    assert (user_rst === exp_rst) else begin
      miscompares++;
      $error("[TB] FAIL user_rst t=%0t observed=%0b expected=%0b", $time, user_rst, exp_rst);
    end
    vectors++;
    assert (clk_ready === !exp_rst) else begin
      miscompares++;
      $error("[TB] FAIL clk_ready t=%0t observed=%0b expected=%0b", $time, clk_ready, !exp_rst);
    end
    vectors++;
    assert (lock_loss_cnt === exp_cnt) else begin
      miscompares++;
      $error("[TB] FAIL lock_loss_cnt t=%0t observed=%0d expected=%0d", $time, lock_loss_cnt, exp_cnt);
    end
  endtask

  task automatic applyStimulus(input bit lk, input bit req, input bit rst);
    bit ls;
    bit was_run;
    mmcm_locked = lk;
    rst_req     = req;
    adc_rst     = rst;
    @(posedge adc_clk);
    #1;
    if (rst) begin
      sync_q.delete();
      repeat (SYNC_STAGES) sync_q.push_back(1'b0);
      streak     = 0;
      loss_model = 0;
    end else begin
      ls = sync_q.pop_front();
      sync_q.push_back(lk);
      was_run = (streak > HOLD_CYCLES);
      if (ls && !req) begin
        if (streak <= HOLD_CYCLES) streak++;
      end else begin
        if (was_run && !ls && CNT_EN && (loss_model < (1 << CNT_W) - 1)) loss_model++;
        streak = 0;
      end
    end
    checkOutput();
  endtask

  initial begin
    int n;
    int seg_len;
    bit seg_lk;

    $display("[TB] start: HOLD_CYCLES=%0d SYNC_STAGES=%0d CNT_W=%0d CNT_EN=%0b",
             HOLD_CYCLES, SYNC_STAGES, CNT_W, CNT_EN);
    repeat (SYNC_STAGES) sync_q.push_back(1'b0);
    streak     = 0;
    loss_model = 0;

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    // Release latency, measured from the first edge that sees lock.
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      n++;
    end while (user_rst !== 1'b0 && n < 40);
    vectors++;
    assert (n === SYNC_STAGES + 1 + HOLD_CYCLES) else begin
      miscompares++;
      $error("[TB] FAIL release_latency observed=%0d expected=%0d", n, SYNC_STAGES + 1 + HOLD_CYCLES);
    end
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);

    // Lock glitch seen by the FSM at hold count 5.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (14) applyStimulus(1'b1, 1'b0, 1'b0);

    // Lock loss in RUN, then recovery.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);

    // Synchronized lock loss coincides with rst_req: loss wins.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);

    // rst_req pulse in RUN, then rst_req held high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (11) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);

    // Counter saturation.
    repeat (17) begin
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
    end

    // adc_rst while running.
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);

    // Randomized segments of lock/unlock with sporadic requests and resets.
    repeat (60) begin
      seg_lk  = ($urandom_range(0, 3) != 0);
      seg_len = int'($urandom_range(1, 15));
      repeat (seg_len)
        applyStimulus(seg_lk, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
